// File: rtl/pipelined_checked_csa.sv
// rtl/pipelined_checked_csa.sv - two-stage duplicated carry-select adder with parity prediction, handshake and error counter
// Optional feature macro: PIPELINED_CHECKED_CSA_ERR_CNT_EN (builds the saturating error counter)
module pipelined_checked_csa #(
    parameter int WIDTH = 78,
    parameter int SPLIT = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             pa,
    input  logic             pb,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ps,
    output logic             par_err,
    output logic             dup_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int HI = WIDTH - SPLIT;

    // pipeline control
    logic v1;
    logic v2;
    logic adv1;
    logic adv2;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // stage 1 combinational: low-half sums on both rails
    logic [SPLIT-1:0] a_lo;
    logic [SPLIT-1:0] b_lo;
    logic [SPLIT:0]   lo_sum_p;
    logic [SPLIT:0]   lo_sum_d;
    logic             lo_cpar_n;
    logic             par1_n;

    assign a_lo = a[SPLIT-1:0];
    assign b_lo = b[SPLIT-1:0];

    // Primary rail is the plain sum; the duplicate rail adds the complemented
    // operands and complemented carry, which yields the complement of the
    // true (SPLIT+1)-bit sum without sharing any adder logic.
    assign lo_sum_p = {1'b0, a_lo} + {1'b0, b_lo} + {{SPLIT{1'b0}}, c_in};
    assign lo_sum_d = {1'b0, ~a_lo} + {1'b0, ~b_lo} + {{SPLIT{1'b0}}, ~c_in};

    // True per-bit carry-ins recovered from the duplicate rail (bit 0 is c_in)
    assign lo_cpar_n = ^(a_lo ^ b_lo ^ ~lo_sum_d[SPLIT-1:0]);
    assign par1_n    = pa ^ pb ^ (^(a ^ b));

    // stage 1 registers
    logic [SPLIT-1:0] lo_p;
    logic [SPLIT-1:0] lo_d;
    logic             co_p;
    logic             co_d;
    logic [HI-1:0]    a_hi;
    logic [HI-1:0]    b_hi;
    logic             papb;
    logic             cpar_lo;
    logic             perr1;

    // stage 1 valid: refill whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
        end
    end

    // stage 1 data: capture only on an actual accept, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_p    <= '0;
            lo_d    <= '0;
            co_p    <= 1'b0;
            co_d    <= 1'b0;
            a_hi    <= '0;
            b_hi    <= '0;
            papb    <= 1'b0;
            cpar_lo <= 1'b0;
            perr1   <= 1'b0;
        end else if (adv1 && in_valid) begin
            lo_p    <= lo_sum_p[SPLIT-1:0];
            co_p    <= lo_sum_p[SPLIT];
            lo_d    <= lo_sum_d[SPLIT-1:0];
            co_d    <= lo_sum_d[SPLIT];
            a_hi    <= a[WIDTH-1:SPLIT];
            b_hi    <= b[WIDTH-1:SPLIT];
            papb    <= pa ^ pb;
            cpar_lo <= lo_cpar_n;
            perr1   <= par1_n;
        end
    end

    // stage 2 combinational: upper-half sums, each rail with its own carry
    logic [HI:0]      hi_sum_p;
    logic [HI:0]      hi_sum_d;
    logic [WIDTH-1:0] sum_p;
    logic [WIDTH-1:0] sum_d;
    logic             cout_p;
    logic             cout_d;
    logic             mism_n;
    logic             ps_n;

    // co_d is already the complement of the true carry, so feeding it as the
    // carry-in keeps the duplicate rail in complemented form
    assign hi_sum_p = {1'b0, a_hi} + {1'b0, b_hi} + {{HI{1'b0}}, co_p};
    assign hi_sum_d = {1'b0, ~a_hi} + {1'b0, ~b_hi} + {{HI{1'b0}}, co_d};

    assign sum_p  = {hi_sum_p[HI-1:0], lo_p};
    assign cout_p = hi_sum_p[HI];
    assign sum_d  = {hi_sum_d[HI-1:0], lo_d};
    assign cout_d = hi_sum_d[HI];

    // a healthy pair differs in every bit; any equal bit is a rail fault
    assign mism_n = (|(~(sum_p ^ sum_d))) || !(cout_p ^ cout_d);
    assign ps_n   = papb ^ cpar_lo ^ (^(a_hi ^ b_hi ^ ~hi_sum_d[HI-1:0]));

    // stage 2 valid: take stage 1 contents whenever the output slot frees
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
        end
    end

    // stage 2 result registers: hold while stalled so outputs stay stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= '0;
            c_out   <= 1'b0;
            ps      <= 1'b0;
            par_err <= 1'b0;
            dup_err <= 1'b0;
        end else if (adv2 && v1) begin
            s       <= sum_p;
            c_out   <= cout_p;
            ps      <= ps_n;
            par_err <= perr1;
            dup_err <= mism_n;
        end
    end

`ifdef PIPELINED_CHECKED_CSA_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt;

    // saturating fault counter; clear has priority over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (v2 && out_ready && (par_err || dup_err) && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign err_cnt = cnt;
`else
    logic unused_clr;

    assign unused_clr = clr_cnt;
    assign err_cnt    = '0;
`endif

endmodule
